// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage with an external data-memory port.
package mem_pkg;

    localparam int unsigned XLEN_DEF = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Sub-word store lane placement, load lane extraction/extension and alignment check.
module lsu_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        offset,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   load_data,
    output logic              misaligned
);

    logic [XLEN-1:0] byte_lane;
    logic [XLEN-1:0] half_lane;

    always_comb begin
        byte_lane = rdata >> {offset, 3'b000};
        half_lane = rdata >> {offset[1], 4'b0000};
    end

    always_comb begin
        be         = '0;
        wdata      = store_data;
        load_data  = rdata;
        misaligned = 1'b0;
        unique case (funct3)
            F3_B, F3_BU: begin
                be    = (XLEN/8)'(1) << offset;
                wdata = {(XLEN/8){store_data[7:0]}};
                if (funct3 == F3_B)
                    load_data = {{(XLEN-8){byte_lane[7]}}, byte_lane[7:0]};
                else
                    load_data = {{(XLEN-8){1'b0}}, byte_lane[7:0]};
            end
            F3_H, F3_HU: begin
                be         = (XLEN/8)'(3) << offset;
                wdata      = {(XLEN/16){store_data[15:0]}};
                misaligned = offset[0];
                if (funct3 == F3_H)
                    load_data = {{(XLEN-16){half_lane[15]}}, half_lane[15:0]};
                else
                    load_data = {{(XLEN-16){1'b0}}, half_lane[15:0]};
            end
            F3_W: begin
                be         = '1;
                misaligned = (offset != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM stage with valid/ready data-memory request, rvalid response, timeout and the MEM/WB register.
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int unsigned XLEN    = XLEN_DEF,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                FlushM,
    input  logic                RegWriteM,
    input  logic                MemWriteM,
    input  logic                MemReadM,
    input  logic                ResultSrcM,
    input  logic [2:0]          Funct3M,
    input  logic [REG_AW-1:0]   DestinationRegM,
    input  logic [XLEN-1:0]     NextPCM,
    input  logic [XLEN-1:0]     WriteDataM,
    input  logic [XLEN-1:0]     ALUResultM,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN/8-1:0]   dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_ready,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                StallM,
    output logic                RegWriteW,
    output logic                ResultSrcW,
    output logic [REG_AW-1:0]   DestinationRegW,
    output logic [XLEN-1:0]     NextPCW,
    output logic [XLEN-1:0]     ALUResultW,
    output logic [XLEN-1:0]     ReadDataW,
    output logic                MisalignW,
    output logic                BusErrW
);

    if (XLEN != 32 || TIMEOUT < 2) begin : g_bad_param
        $error("mem_stage_hs: XLEN must be 32 and TIMEOUT at least 2");
    end

    localparam int unsigned CW = $clog2(TIMEOUT + 2);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic              memop, mis_raw, mis, timeout;
    logic [XLEN/8-1:0] be_a;
    logic [XLEN-1:0]   wdata_a, load_a;
    logic              req, stall, capture, load_done, bus_err, mis_flag;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (Funct3M),
        .offset     (ALUResultM[1:0]),
        .store_data (WriteDataM),
        .rdata      (dmem_rdata),
        .be         (be_a),
        .wdata      (wdata_a),
        .load_data  (load_a),
        .misaligned (mis_raw)
    );

    always_comb begin
        memop   = MemReadM | MemWriteM;
        mis     = memop & mis_raw;
        timeout = (cnt >= TO_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (req && dmem_ready && !MemWriteM) state_next = WAIT;
            WAIT: begin
                if (dmem_rvalid)  state_next = IDLE;
                else if (FlushM)  state_next = DRAIN;
                else if (timeout) state_next = IDLE;
            end
            DRAIN: if (dmem_rvalid || timeout) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A flush in WAIT without rvalid lets the outstanding response drain before new requests.
    always_comb begin
        req       = 1'b0;
        stall     = 1'b0;
        capture   = 1'b0;
        load_done = 1'b0;
        bus_err   = 1'b0;
        mis_flag  = 1'b0;
        unique case (state)
            IDLE: begin
                req      = memop & ~mis & ~FlushM;
                stall    = req & ~(dmem_ready & MemWriteM);
                capture  = ~FlushM & ~mis & ~stall;
                mis_flag = mis & ~FlushM;
            end
            WAIT: begin
                stall     = ~dmem_rvalid;
                load_done = dmem_rvalid & ~FlushM;
                capture   = load_done;
                bus_err   = ~dmem_rvalid & ~FlushM & timeout;
            end
            DRAIN:   stall = memop;
            default: stall = 1'b0;
        endcase
        if (rst) begin
            req      = 1'b0;
            stall    = 1'b0;
            capture  = 1'b0;
            bus_err  = 1'b0;
            mis_flag = 1'b0;
        end
    end

    always_comb begin
        dmem_req   = req;
        dmem_we    = req & MemWriteM;
        dmem_be    = req ? be_a : '0;
        dmem_addr  = {ALUResultM[XLEN-1:2], 2'b00};
        dmem_wdata = wdata_a;
        StallM     = stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == IDLE) begin
            cnt <= (state_next == WAIT) ? CW'(1) : '0;
        end else begin
            cnt <= (state_next == IDLE) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteW       <= 1'b0;
            ResultSrcW      <= 1'b0;
            DestinationRegW <= '0;
            NextPCW         <= '0;
            ALUResultW      <= '0;
            ReadDataW       <= '0;
            MisalignW       <= 1'b0;
            BusErrW         <= 1'b0;
        end else begin
            MisalignW <= mis_flag;
            BusErrW   <= bus_err;
            if (capture) begin
                RegWriteW       <= RegWriteM;
                ResultSrcW      <= ResultSrcM;
                DestinationRegW <= DestinationRegM;
                NextPCW         <= NextPCM;
                ALUResultW      <= ALUResultM;
                if (load_done) ReadDataW <= load_a;
            end else begin
                RegWriteW       <= 1'b0;
                DestinationRegW <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed and randomized checks of mem_stage_hs against a behavioural access model.
module tb_mem_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        FlushM, RegWriteM, MemWriteM, MemReadM, ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  DestinationRegM;
    logic [31:0] NextPCM, WriteDataM, ALUResultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        StallM, RegWriteW, ResultSrcW, MisalignW, BusErrW;
    logic [4:0]  DestinationRegW;
    logic [31:0] NextPCW, ALUResultW, ReadDataW;

    int checks = 0;
    int failures = 0;

    mem_stage_hs #(.XLEN(32), .REG_AW(5), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .FlushM(FlushM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .DestinationRegM(DestinationRegM),
        .NextPCM(NextPCM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .StallM(StallM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .DestinationRegW(DestinationRegW),
        .NextPCW(NextPCW), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .MisalignW(MisalignW), .BusErrW(BusErrW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        FlushM = 0; RegWriteM = 0; MemWriteM = 0; MemReadM = 0; ResultSrcM = 0;
        Funct3M = 0; DestinationRegM = 0; NextPCM = 0; WriteDataM = 0; ALUResultM = 0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    // Reference rules written from the access-size table with plain arithmetic.
    function automatic bit m_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
        if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1;
        if (f3 == 2 && (a % 4 != 0)) return 1;
        return 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned off = a % 4;
        if (f3 == 0 || f3 == 4) return 4'(1 << off);
        if (f3 == 1 || f3 == 5) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 0) return (d % 256) * 32'h0101_0101;
        if (f3 == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        if (f3 == 0 || f3 == 4) begin
            v = v % 256;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f3 == 1 || f3 == 5) begin
            v = v % 65536;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                            input int unsigned rdy_dly, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        logic [31:0] npc = $urandom;
        clear_in();
        MemWriteM = 1; Funct3M = f3; ALUResultM = a; WriteDataM = d; NextPCM = npc;
        for (int i = 0; i < int'(rdy_dly); i++) begin
            #1;
            chk("st_wait_req", dmem_req, 1);
            chk("st_wait_stall", StallM, 1);
            tick();
            chk("st_wait_bubble", RegWriteW, 0);
        end
        dmem_ready = 1;
        #1;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk("st_be", dmem_be, exp_be);
        chk("st_wdata", dmem_wdata, exp_wd);
        chk("st_stall", StallM, 0);
        tick();
        chk("st_regwrite", RegWriteW, 0);
        chk("st_npc", NextPCW, npc);
        clear_in();
    endtask

    task automatic issue_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                              input int unsigned rdy_dly, input logic [31:0] npc);
        clear_in();
        MemReadM = 1; RegWriteM = 1; ResultSrcM = 1; Funct3M = f3; DestinationRegM = rd;
        ALUResultM = a; NextPCM = npc; WriteDataM = $urandom;
        for (int i = 0; i < int'(rdy_dly); i++) begin
            #1;
            chk("ld_hold_req", dmem_req, 1);
            chk("ld_hold_addr", dmem_addr, a & 32'hFFFF_FFFC);
            chk("ld_hold_stall", StallM, 1);
            tick();
            chk("ld_hold_bubble_rd", DestinationRegW, 0);
        end
        dmem_ready = 1;
        #1;
        chk("ld_req", dmem_req, 1);
        chk("ld_we", dmem_we, 0);
        chk("ld_addr", dmem_addr, a & 32'hFFFF_FFFC);
        chk("ld_stall", StallM, 1);
        tick();
        dmem_ready = 0;
        chk("ld_accept_bubble", RegWriteW, 0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] rdata, input int unsigned rdy_dly,
                           input int unsigned rv_dly, input logic [31:0] exp);
        logic [31:0] npc = $urandom;
        issue_load(a, f3, rd, rdy_dly, npc);
        for (int i = 1; i < int'(rv_dly); i++) begin
            #1;
            chk("ld_wait_stall", StallM, 1);
            chk("ld_wait_req", dmem_req, 0);
            tick();
            chk("ld_wait_bubble", RegWriteW, 0);
        end
        dmem_rvalid = 1; dmem_rdata = rdata;
        #1;
        chk("ld_rvalid_stall", StallM, 0);
        tick();
        dmem_rvalid = 0;
        chk("ld_wb_regwrite", RegWriteW, 1);
        chk("ld_wb_rd", DestinationRegW, rd);
        chk("ld_wb_data", ReadDataW, exp);
        chk("ld_wb_resultsrc", ResultSrcW, 1);
        chk("ld_wb_npc", NextPCW, npc);
        chk("ld_wb_alu", ALUResultW, a);
        clear_in();
    endtask

    task automatic do_mis(input logic [31:0] a, input logic [2:0] f3, input bit is_store);
        clear_in();
        MemWriteM = is_store; MemReadM = !is_store; RegWriteM = !is_store;
        DestinationRegM = 5'd9; Funct3M = f3; ALUResultM = a; dmem_ready = 1;
        #1;
        chk("mis_noreq", dmem_req, 0);
        chk("mis_nostall", StallM, 0);
        tick();
        chk("mis_flag", MisalignW, 1);
        chk("mis_regwrite", RegWriteW, 0);
        chk("mis_rd", DestinationRegW, 0);
        clear_in();
        tick();
        chk("mis_pulse_end", MisalignW, 0);
    endtask

    task automatic do_alu(input logic [2:0] f3, input logic rw, input logic [4:0] rd,
                          input logic [31:0] res);
        logic [31:0] npc = $urandom;
        clear_in();
        Funct3M = f3; RegWriteM = rw; DestinationRegM = rd; ALUResultM = res; NextPCM = npc;
        #1;
        chk("alu_noreq", dmem_req, 0);
        chk("alu_nostall", StallM, 0);
        tick();
        chk("alu_regwrite", RegWriteW, rw);
        chk("alu_rd", DestinationRegW, rd);
        chk("alu_res", ALUResultW, res);
        chk("alu_npc", NextPCW, npc);
        chk("alu_nomis", MisalignW, 0);
        clear_in();
    endtask

    initial begin
        clear_in();
        rst = 1;
        MemWriteM = 1; Funct3M = 3'd2; ALUResultM = 32'h100; WriteDataM = 32'h1234_5678;
        RegWriteM = 1; DestinationRegM = 5'd3; dmem_ready = 1;
        #2;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_be", dmem_be, 0);
        tick();
        tick();
        chk("rst_regwrite", RegWriteW, 0);
        chk("rst_rd", DestinationRegW, 0);
        chk("rst_npc", NextPCW, 0);
        chk("rst_rdata", ReadDataW, 0);
        rst = 0;
        clear_in();

        do_store(32'h100, 3'd2, 32'hDEAD_BEEF, 0, 4'hF, 32'hDEAD_BEEF);
        do_load(32'h103, 3'd0, 5'd5, 32'h8011_2233, 0, 3, 32'hFFFF_FF80);
        do_load(32'h103, 3'd4, 5'd6, 32'h8011_2233, 0, 3, 32'h0000_0080);
        do_store(32'h102, 3'd1, 32'h0000_ABCD, 0, 4'b1100, 32'hABCD_ABCD);
        do_mis(32'h101, 3'd1, 0);
        do_load(32'h204, 3'd2, 5'd8, 32'hCAFE_F00D, 2, 1, 32'hCAFE_F00D);

        // Flush in WAIT, drain the late response, then a plain ALU op.
        issue_load(32'h300, 3'd2, 5'd10, 0, 32'h44);
        FlushM = 1;
        #1;
        chk("fl_wait_stall", StallM, 1);
        chk("fl_wait_req", dmem_req, 0);
        tick();
        clear_in();
        MemReadM = 1; Funct3M = 3'd2; ALUResultM = 32'h400;
        #1;
        chk("drain_memop_stall", StallM, 1);
        chk("drain_memop_req", dmem_req, 0);
        tick();
        chk("drain_bubble", RegWriteW, 0);
        clear_in();
        dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
        #1;
        chk("drain_stall", StallM, 0);
        tick();
        clear_in();
        chk("drain_discard", RegWriteW, 0);
        chk("drain_no_buserr", BusErrW, 0);
        do_alu(3'd0, 1, 5'd7, 32'h0000_1234);

        // Flush and rvalid together: response discarded, back to IDLE.
        issue_load(32'h500, 3'd2, 5'd11, 0, 32'h48);
        FlushM = 1; dmem_rvalid = 1; dmem_rdata = 32'h5555_AAAA;
        tick();
        chk("flrv_discard", RegWriteW, 0);
        do_alu(3'd6, 1, 5'd12, 32'h0000_0BAD);

        // No response: bus error after the timeout.
        issue_load(32'h600, 3'd2, 5'd13, 0, 32'h4C);
        for (int w = 1; w <= 16; w++) begin
            #1;
            chk("to_stall", StallM, 1);
            tick();
            chk("to_buserr", BusErrW, (w == 16) ? 1 : 0);
            chk("to_regwrite", RegWriteW, 0);
        end
        clear_in();
        tick();
        chk("to_buserr_pulse_end", BusErrW, 0);

        // Reset in the middle of WAIT, then a stray rvalid.
        do_alu(3'd0, 1, 5'd14, 32'h0000_7777);
        issue_load(32'h700, 3'd2, 5'd15, 0, 32'h50);
        tick();
        tick();
        rst = 1;
        #1;
        chk("mrst_stall", StallM, 0);
        tick();
        rst = 0;
        clear_in();
        chk("mrst_regwrite", RegWriteW, 0);
        chk("mrst_rd", DestinationRegW, 0);
        chk("mrst_alu", ALUResultW, 0);
        chk("mrst_npc", NextPCW, 0);
        chk("mrst_resultsrc", ResultSrcW, 0);
        dmem_rvalid = 1; dmem_rdata = 32'h9999_9999;
        #1;
        chk("stray_stall", StallM, 0);
        tick();
        clear_in();
        chk("stray_rdata", ReadDataW, 0);
        chk("stray_regwrite", RegWriteW, 0);

        for (int n = 0; n < 60; n++) begin
            int unsigned kind = $urandom_range(0, 2);
            logic [31:0] a = $urandom;
            logic [31:0] d = $urandom;
            logic [2:0]  f3 = 3'($urandom_range(0, 7));
            if (kind == 0) begin
                do_alu(f3, 1'($urandom_range(0, 1)), 5'($urandom), d);
            end else if (kind == 1) begin
                if (f3 == 4 || f3 == 5) f3 = 3'(f3 - 4);
                if (m_mis(f3, a)) do_mis(a, f3, 1);
                else do_store(a, f3, d, $urandom_range(0, 2), m_be(f3, a), m_wdata(f3, d));
            end else begin
                if (m_mis(f3, a)) do_mis(a, f3, 0);
                else do_load(a, f3, 5'($urandom_range(1, 31)), d, $urandom_range(0, 2),
                             $urandom_range(1, 3), m_load(f3, a, d));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Parametrised MEM-stage successor for the 5-stage RISC-V pipeline: memory access plus the MEM/WB pipeline register.
- Replaces the single-cycle internal data memory with an external data-memory port using a valid/ready request and an rvalid response.
- Adds RV32I sub-word loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW), misalignment detection, a wait-timeout, flush, and a stall output to the hazard unit.

Parameters:
- XLEN, 32, datapath/address width; only 32 is supported, and elaboration fails otherwise.
- REG_AW, 5, destination register index width.
- TIMEOUT, 16, maximum cycles spent in WAIT before a bus error is declared (at least 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- FlushM  in  1  kill the instruction currently in MEM.
- RegWriteM, MemWriteM, MemReadM, ResultSrcM  in  1 each  control from the EX/MEM register.
- Funct3M  in  3  load/store size and sign.
- DestinationRegM  in  REG_AW  rd.
- NextPCM, WriteDataM, ALUResultM  in  XLEN  PC+4, rs2 data, effective address.
- dmem_req  out  1  request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  XLEN  word-aligned address ({ALUResultM[XLEN-1:2],2'b00}).
- dmem_be  out  XLEN/8  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_ready  in  1  request accepted.
- dmem_rvalid  in  1  load data valid.
- dmem_rdata  in  XLEN  load word.
- StallM  out  1  hold IF..EX/MEM this cycle.
- RegWriteW, ResultSrcW  out  1  registered control.
- DestinationRegW  out  REG_AW.
- NextPCW, ALUResultW, ReadDataW  out  XLEN.
- MisalignW, BusErrW  out  1  registered one-cycle exception flags.

Behaviour:
- Reset: synchronous, active-high; wins over every other input. It forces state IDLE, the timeout counter to 0, and every W output and flag to 0. dmem_req, StallM, dmem_we and dmem_be are 0 during reset. An rvalid arriving after reset is ignored.
- memop = MemReadM | MemWriteM.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- FSM states IDLE, WAIT, DRAIN.
- IDLE, normal issue:
  - dmem_req = memop & ~misaligned & ~FlushM (combinational).
  - StallM = dmem_req & ~(dmem_ready & dmem_we).
  - Store accepted (ready=1): retires in the same cycle; the W register loads.
  - Load accepted (ready=1): go to WAIT, timeout counter = 1.
  - Request not accepted (ready=0): stay in IDLE with StallM=1. The request stays asserted with stable fields; the upstream register holds its inputs.
- IDLE, no memory operation: the W register captures the inputs with zero latency, matching the single-cycle register behaviour.
- WAIT:
  - StallM=1, dmem_req=0.
  - rvalid=1: W captures the extended load data, go to IDLE; StallM=0 in that cycle.
  - FlushM=1 without rvalid: go to DRAIN.
  - Counter reaches TIMEOUT: BusErrW pulses, RegWriteW=0, go to IDLE.
- DRAIN:
  - StallM=0, dmem_req=0; the W register takes bubbles.
  - An instruction in MEM whose memop is 1 waits in DRAIN: dmem_req=0, StallM=1.
  - rvalid=1 or timeout: data is discarded, no BusErrW pulse, go to IDLE.
- Bubble rule: any cycle with StallM=1, FlushM=1, misaligned or timeout loads W with RegWriteW=0 and DestinationRegW=0. The other W fields are don't-care but deterministic: they hold.
- Misaligned: no request is issued. MisalignW=1 for one cycle, RegWriteW=0, no stall.
- Stores: offset = addr[1:0].
  - SB: be = 4'b0001 << offset, wdata = byte replicated ×4.
  - SH: be = 4'b0011 << offset, wdata = half replicated ×2.
  - SW: be = 4'hF.
- Loads: select the lane by offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Funct3 values 3, 6, 7 are illegal: treated as misaligned.
- Loads with zero-wait memory (ready=1, rvalid next cycle) take one stall cycle; stores take none.
- Simultaneous flush and rvalid in WAIT: data is discarded, go to IDLE.

Decomposition:
- Package mem_pkg:
  - Funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {IDLE, WAIT, DRAIN}.
  - XLEN default.
- Sub-module lsu_align (combinational):
  - Inputs: Funct3, offset, store data, rdata.
  - Outputs: be, wdata, extended load data, misaligned.
- Top level: FSM, timeout counter, MEM/WB register.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ready=1 → be=F, wdata=0xDEADBEEF, StallM=0, next cycle RegWriteW=0.
- LB addr 0x103, ready=1, rvalid after 3 cycles with rdata 0x80112233 → StallM high for 3 cycles; ReadDataW=0xFFFFFF80. Same access with LBU → 0x00000080.
- SH addr 0x102 data 0x0000ABCD → be=4'b1100, wdata=0xABCDABCD. LH addr 0x101 → no dmem_req, MisalignW=1 for one cycle, RegWriteW=0.
- Load with ready=0 for 2 cycles → dmem_req and dmem_addr stable for 3 cycles, StallM=1 throughout, single writeback.
- Load in WAIT, FlushM pulse, then rvalid 2 cycles later → DRAIN, no RegWriteW, then a following ADD (no memop) writes back normally.
- No rvalid for TIMEOUT=16 cycles → BusErrW=1 at cycle 16; rst asserted mid-WAIT → IDLE and all W outputs 0 next edge, a stray rvalid ignored.
